// File: rtl/cnn_pkg.sv
// Shared arithmetic helpers for the CNN datapath: rounding shift and signed saturation.
// Helpers work on a 64-bit signed carrier; callers sign-extend in and truncate out.
package cnn_pkg;

    localparam int DEFAULT_ACC_WIDTH = 40;
    localparam int WIDE              = 64;

    typedef logic signed [WIDE-1:0] wide_t;

    // Round half up, then arithmetic shift; the wide carrier absorbs the rounding carry.
    function automatic wide_t round_shift(input wide_t value, input int shift);
        return (value + (wide_t'(1) <<< (shift - 1))) >>> shift;
    endfunction

    function automatic wide_t sat_signed(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: round, arithmetic right shift by SHIFT, saturate to OUT_WIDTH signed.
// Latency: purely combinational.
// Backpressure: none; no state.
module requant_sat
    import cnn_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int SHIFT     = 8,
    parameter int OUT_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0] value,
    output logic signed [OUT_WIDTH-1:0] result
);

    wide_t value_ext;

    assign value_ext = {{(WIDE - ACC_WIDTH){value[ACC_WIDTH-1]}}, value};
    assign result    = OUT_WIDTH'(sat_signed(round_shift(value_ext, SHIFT), OUT_WIDTH));

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums NUM_PARTIALS adder-tree beats, requantizes, holds result.
// Latency: out_valid rises TREE_LATENCY+1 cycles after the final in_valid of a group.
// Backpressure: never stalls the tree; an unconsumed result is overwritten and flags overflow.
module psum_accumulator
    import cnn_pkg::*;
#(
    parameter int TREE_LATENCY = 3,
    parameter int NUM_PARTIALS = 4,
    parameter int ACC_WIDTH    = DEFAULT_ACC_WIDTH,
    parameter int SHIFT        = 8,
    parameter int OUT_WIDTH    = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [31:0]                 tree_out,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        overflow
);

    localparam int              CNT_W = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_PARTIALS - 1);

    logic [TREE_LATENCY-1:0]     vld_dly;
    logic                        beat_valid;
    logic                        last_beat;
    logic [CNT_W-1:0]            count;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] beat_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] result;

    // The tree has a fixed depth, so a matched delay on in_valid marks its result cycle.
    assign beat_valid = vld_dly[TREE_LATENCY-1];
    assign beat_ext   = {{(ACC_WIDTH - 32){tree_out[31]}}, tree_out};
    assign sum        = ((count == '0) ? '0 : acc) + beat_ext;
    assign last_beat  = beat_valid && (count == LAST);
    assign busy       = (count != '0);

    requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
        .value  (sum),
        .result (result)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_dly   <= '0;
            count     <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            vld_dly[0] <= in_valid;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                vld_dly[i] <= vld_dly[i-1];
            end

            if (beat_valid) begin
                if (count == LAST) begin
                    count <= '0;
                end else begin
                    acc   <= sum;
                    count <= count + CNT_W'(1);
                end
            end

            // A new result always wins the register; losing an unread one is recorded.
            if (last_beat) begin
                out_data  <= result;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed plan scenarios plus randomized traffic,
// checked every cycle against a group-level reference model.
module tb_psum_accumulator;

    localparam int TL = 3;
    localparam int NP = 4;
    localparam int SH = 2;
    localparam int OW = 8;

    logic                 clock     = 1'b0;
    logic                 reset     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b1;
    logic [31:0]          tree_out  = '0;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 busy;
    logic                 overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Upstream tree model: values ride alongside in_valid and emerge TL cycles later.
    bit pv [TL];
    int pd [TL];

    // Reference: beats collected into the current group, plus the visible output state.
    int     grp [$];
    bit     m_valid = 1'b0;
    longint m_data  = 0;
    bit     m_ovf   = 1'b0;
    int     cyc_since_in = 0;

    always #5 clock = ~clock;

    psum_accumulator #(
        .TREE_LATENCY (TL),
        .NUM_PARTIALS (NP),
        .ACC_WIDTH    (40),
        .SHIFT        (SH),
        .OUT_WIDTH    (OW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .tree_out  (tree_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rounded division by 2^SH (floor of (s + half) / 2^SH), then clamp to OW bits.
    function automatic longint requant(input longint s);
        longint n;
        longint q;
        longint lim;
        n   = s + longint'(2 ** (SH - 1));
        q   = n / longint'(2 ** SH);
        if ((n % longint'(2 ** SH)) != 0 && n < 0) begin
            q = q - 1;
        end
        lim = longint'(2 ** (OW - 1));
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return q;
    endfunction

    task automatic tick(input bit v, input int val, input bit rdy);
        bit     beat;
        int     bval;
        bit     done;
        longint s;
        beat      = pv[TL-1];
        bval      = pd[TL-1];
        in_valid  = v;
        out_ready = rdy;
        tree_out  = beat ? bval : $urandom;
        for (int i = TL - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = v;
        pd[0] = val;
        @(posedge clock);
        #1;
        done = 1'b0;
        if (beat) begin
            grp.push_back(bval);
            if (grp.size() == NP) begin
                s = 0;
                foreach (grp[i]) s += longint'(grp[i]);
                if (m_valid && !rdy) m_ovf = 1'b1;
                m_data  = requant(s);
                m_valid = 1'b1;
                done    = 1'b1;
                grp.delete();
            end
        end
        if (!done && m_valid && rdy) m_valid = 1'b0;
        cyc_since_in = v ? 1 : cyc_since_in + 1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("busy", busy, grp.size() != 0);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < TL; i++) pv[i] = 1'b0;
        grp.delete();
        m_valid = 1'b0;
        m_data  = 0;
        m_ovf   = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic send_group(input int vals[4], input int maxgap, input bit rdy, input bit quiet);
        bit seen;
        int gap;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 0, rdy);
                seen |= out_valid;
            end
            tick(1'b1, vals[i], rdy);
            seen |= out_valid;
        end
        if (quiet) check("early_out", seen, 0);
    endtask

    task automatic wait_result(input string tag, input longint exp, input int exp_lat);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            tick(1'b0, 0, 1'b1);
        end
        if (found) begin
            check(tag, out_data, exp);
            if (exp_lat > 0) check({tag, "_lat"}, cyc_since_in, exp_lat);
        end else begin
            check({tag, "_timeout"}, 0, 1);
        end
        tick(1'b0, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g [4];
        int v;
        for (int i = 0; i < TL; i++) begin
            pv[i] = 1'b0;
            pd[i] = 0;
        end
        do_reset();

        g = '{36, 61, 33, 10};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("basic", 35, TL + 1);

        g = '{1000, 1000, 1000, 1000};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("sat_pos", 127, TL + 1);
        g = '{-1000, -1000, -1000, -1000};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("sat_neg", -128, TL + 1);

        g = '{1, 1, 0, 0};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("round_a", 1, TL + 1);
        g = '{-3, 0, 0, 0};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("round_b", -1, TL + 1);
        g = '{5, 0, 0, 0};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("round_c", 1, TL + 1);

        g = '{36, 61, 33, 10};
        send_group(g, 5, 1'b1, 1'b1);
        wait_result("gapped", 35, TL + 1);

        g = '{4, 4, 4, 4};
        send_group(g, 0, 1'b0, 1'b1);
        g = '{8, 8, 8, 8};
        send_group(g, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 0, 1'b0);
        check("bp_data", out_data, 8);
        check("bp_overflow", overflow, 1);
        check("bp_valid", out_valid, 1);
        tick(1'b0, 0, 1'b1);
        check("bp_drain_valid", out_valid, 0);
        check("bp_drain_overflow", overflow, 1);
        tick(1'b0, 0, 1'b0);

        tick(1'b1, 100, 1'b1);
        tick(1'b1, 100, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 0, 1'b1);
        check("mid_busy", busy, 1);
        do_reset();
        g = '{4, 4, 4, 4};
        send_group(g, 0, 1'b1, 1'b1);
        wait_result("after_reset", 4, TL + 1);
        check("after_reset_ovf", overflow, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) v = int'($urandom);
                else v = int'($urandom_range(0, 4000)) - 2000;
                tick(1'(($urandom_range(0, 1))), v, $urandom_range(0, 3) != 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
